// File: rtl/b09_rr_sched_if.sv
// Handshake bundle between requesters, the round-robin scheduler and the b09 converter core.
// Latency: none, wires only.
// Backpressure: none; requesters hold req until their done pulse.
//
// Signals:
//   req[NREQ]       request level per requester
//   word[8*NREQ]    requester i's word at bits [8i+7:8i]
//   gnt[NREQ]       one-hot grant
//   done            one-cycle transaction-complete pulse
//   rsp_data[8]     captured response word
//   rsp_none        no response arrived before timeout
//   busy            scheduler not idle
//   core_x          serial frame to the converter core
//   core_y          serial response from the converter core
interface b09_rr_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] word;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [7:0]        rsp_data;
    logic              rsp_none;
    logic              busy;
    logic              core_x;
    logic              core_y;

    // Requester fabric plus converter core side.
    modport master (
        output req, word, core_y,
        input  gnt, done, rsp_data, rsp_none, busy, core_x
    );

    // Scheduler side.
    modport slave (
        input  req, word, core_y,
        output gnt, done, rsp_data, rsp_none, busy, core_x
    );
endinterface

// File: rtl/b09_rr_sched.sv
// Round-robin scheduler sharing one b09 serial converter core among NREQ word requesters.
// Latency: grant 1 cycle after req; done 19 cycles after req at best, 10+TIMEOUT on no response.
// Backpressure: one transaction at a time; waiting requesters hold req until their done.
//
// Ports:
//   clk_i   single clock, rising edge
//   rst_i   synchronous active-high reset
//   bus     b09_rr_sched_if slave modport: req/word/core_y in, gnt/done/rsp_*/busy/core_x out
module b09_rr_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32,
    parameter int GUARD   = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    b09_rr_sched_if.slave bus
);
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CM1  = (TIMEOUT > GUARD) ? TIMEOUT : GUARD;
    localparam int CMAX = (CM1 > 9) ? CM1 : 9;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_LISTEN,
        S_RECV,
        S_GUARD
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      sh_q;
    logic [7:0]      rx_q;
    logic [NREQ-1:0] gnt_q;
    logic            done_q;
    logic [7:0]      rsp_data_q;
    logic            rsp_none_q;
    logic            busy_q;
    logic            core_x_q;

    // Round-robin pick: rotate req so ptr sits at bit 0, take the lowest set bit,
    // then map the offset back to a requester index.
    logic [2*NREQ-1:0] req2_d;
    logic [NREQ-1:0]   rot_d;
    logic [IW:0]       sum_d;
    logic              pick_vld_d;
    logic [IW-1:0]     pick_idx_d;
    logic [7:0]        words_d [NREQ];
    logic [IW-1:0]     ptr_nxt_d;

    always_comb begin
        req2_d     = {bus.req, bus.req} >> ptr_q;
        rot_d      = req2_d[NREQ-1:0];
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        sum_d      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_d[k]) begin
                sum_d = {1'b0, ptr_q} + (IW+1)'(k);
                if (sum_d >= (IW+1)'(NREQ)) begin
                    sum_d = sum_d - (IW+1)'(NREQ);
                end
                pick_vld_d = 1'b1;
                pick_idx_d = sum_d[IW-1:0];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            words_d[k] = bus.word[8*k +: 8];
        end
        ptr_nxt_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            sh_q       <= '0;
            rx_q       <= '0;
            gnt_q      <= '0;
            done_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_none_q <= 1'b0;
            busy_q     <= 1'b0;
            core_x_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_d) begin
                        idx_q    <= pick_idx_d;
                        gnt_q    <= NREQ'(1) << pick_idx_d;
                        sh_q     <= words_d[pick_idx_d];
                        core_x_q <= 1'b1;   // start bit goes out with the grant
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= S_SEND;
                    end
                end
                S_SEND: begin
                    // cnt counts bits already on the wire after the start bit
                    if (cnt_q == CW'(8)) begin
                        core_x_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_LISTEN;
                    end else begin
                        core_x_q <= sh_q[7];
                        sh_q     <= {sh_q[6:0], 1'b0};
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                S_LISTEN: begin
                    // a start bit in the last listen cycle still wins over timeout
                    if (bus.core_y) begin
                        cnt_q   <= '0;
                        state_q <= S_RECV;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q <= 8'h00;
                        rsp_none_q <= 1'b1;
                        done_q     <= 1'b1;
                        ptr_q      <= ptr_nxt_d;
                        cnt_q      <= '0;
                        state_q    <= S_GUARD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RECV: begin
                    rx_q <= {rx_q[6:0], bus.core_y};
                    if (cnt_q == CW'(7)) begin
                        rsp_data_q <= {rx_q[6:0], bus.core_y};
                        rsp_none_q <= 1'b0;
                        done_q     <= 1'b1;
                        ptr_q      <= ptr_nxt_d;
                        cnt_q      <= '0;
                        state_q    <= S_GUARD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_GUARD: begin
                    // done and gnt live only through the first guard cycle
                    done_q <= 1'b0;
                    gnt_q  <= '0;
                    if (cnt_q == CW'(GUARD - 1)) begin
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_none = rsp_none_q;
    assign bus.busy     = busy_q;
    assign bus.core_x   = core_x_q;
endmodule

// File: tb/tb_b09_rr_sched.sv
// Self-checking bench for b09_rr_sched: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_b09_rr_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;
    localparam int GUARD   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    b09_rr_sched_if #(.NREQ(NREQ)) bus ();

    b09_rr_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int cur   = 0;

    // Transaction-timeline model: absolute cycle numbers for grant, done, idle.
    bit         m_valid = 0;
    bit         m_act   = 0;
    int         m_ptr   = 0;
    int         m_idx   = 0;
    int         m_g     = 0;
    int         m_d     = 0;
    int         m_ls    = 0;
    bit         m_dk    = 0;
    bit         m_none  = 0;
    logic [7:0] m_w     = '0;
    logic [7:0] m_rb    = '0;
    logic [7:0] m_rsp_d = '0;
    bit         m_rsp_n = 0;

    logic [NREQ-1:0] e_gnt;
    logic            e_x, e_done, e_busy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, want %0h", nm, cur, act, exp);
        end
    endtask

    task automatic observe();
        @(negedge clk);
        cur    = cyc;
        e_busy = m_act;
        e_gnt  = (m_act && (!m_dk || cur <= m_d)) ? (NREQ'(1) << m_idx) : '0;
        e_x    = 1'b0;
        if (m_act && cur >= m_g && cur <= m_g + 8)
            e_x = (cur == m_g) ? 1'b1 : m_w[8 - (cur - m_g)];
        e_done = m_act && m_dk && (cur == m_d);
        if (m_valid) begin
            chk("gnt",      32'(bus.gnt),   32'(e_gnt));
            chk("core_x",   32'(bus.core_x), 32'(e_x));
            chk("done",     32'(bus.done),  32'(e_done));
            chk("busy",     32'(bus.busy),  32'(e_busy));
            chk("rsp_data", 32'(bus.rsp_data), 32'(m_rsp_d));
            chk("rsp_none", 32'(bus.rsp_none), 32'(m_rsp_n));
        end
    endtask

    task automatic apply(input logic [NREQ-1:0] r, input logic [8*NREQ-1:0] w,
                         input logic y, input logic rs);
        bit found;
        int j;
        bus.req    = r;
        bus.word   = w;
        bus.core_y = y;
        rst        = rs;
        if (rs) begin
            m_act = 0; m_ptr = 0; m_rsp_d = '0; m_rsp_n = 0; m_valid = 1;
        end else if (!m_act) begin
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (!found && r[j]) begin
                    found = 1; m_idx = j;
                end
            end
            if (found) begin
                m_act = 1; m_g = cur + 1; m_w = w[8*m_idx +: 8]; m_dk = 0;
            end
        end else begin
            if (!m_dk && cur >= m_g + 9) begin
                if (y) begin
                    m_dk = 1; m_ls = cur; m_d = cur + 9; m_none = 0; m_rb = '0;
                end else if (cur == m_g + 9 + TIMEOUT - 1) begin
                    m_dk = 1; m_d = cur + 1; m_none = 1;
                end
            end else if (m_dk && !m_none && cur > m_ls && cur <= m_ls + 8) begin
                m_rb = {m_rb[6:0], y};
            end
            if (m_dk && cur + 1 == m_d) begin
                m_rsp_d = m_none ? 8'h00 : m_rb;
                m_rsp_n = m_none;
                m_ptr   = (m_idx + 1) % NREQ;
            end
            if (m_dk && cur + 1 == m_d + GUARD) m_act = 0;
        end
    endtask

    // One directed transaction with literal expectations relative to request edge T.
    task automatic txn(input logic [NREQ-1:0] r, input int idx, input logic [7:0] wd,
                       input int ys, input logic [7:0] yd,
                       input logic [7:0] exp_d, input logic exp_n, input int dexp);
        logic [8*NREQ-1:0] w;
        logic [8:0]        fr;
        logic              yv;
        w = {$urandom, $urandom};
        w[8*idx +: 8] = wd;
        fr = {1'b1, wd};
        observe();
        apply(r, w, 1'b0, 1'b0);
        for (int k = 1; k <= dexp + GUARD; k++) begin
            observe();
            if (k == 1)  chk("lit_gnt", 32'(bus.gnt), 32'(NREQ'(1) << idx));
            if (k <= 9)  chk("lit_frame", 32'(bus.core_x), 32'(fr[9 - k]));
            if (k == 10) chk("lit_x_idle", 32'(bus.core_x), 32'd0);
            if (k == dexp - 1) chk("lit_done_early", 32'(bus.done), 32'd0);
            if (k == dexp) begin
                chk("lit_done", 32'(bus.done), 32'd1);
                chk("lit_rsp_data", 32'(bus.rsp_data), 32'(exp_d));
                chk("lit_rsp_none", 32'(bus.rsp_none), 32'(exp_n));
            end
            if (k == dexp + 1) chk("lit_gnt_drop", 32'(bus.gnt), 32'd0);
            if (k == dexp + GUARD - 1) chk("lit_busy_hi", 32'(bus.busy), 32'd1);
            if (k == dexp + GUARD)     chk("lit_busy_lo", 32'(bus.busy), 32'd0);
            yv = 1'b0;
            if (ys > 0 && k == ys) yv = 1'b1;
            else if (ys > 0 && k > ys && k <= ys + 8) yv = yd[7 - (k - ys - 1)];
            apply((k <= dexp) ? r : '0, w, yv, 1'b0);
        end
    endtask

    initial begin
        logic [NREQ-1:0]   rq;
        logic [8*NREQ-1:0] wd;
        logic [NREQ-1:0]   prevg;
        int                g_idx[$];
        int                g_cyc[$];
        int                yprob;
        int                gi;
        int                lim;
        bus.req = '0; bus.word = '0; bus.core_y = 1'b0;

        observe(); apply('0, '0, 1'b0, 1'b1);
        observe(); apply('0, '0, 1'b0, 1'b1);
        observe();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_x", 32'(bus.core_x), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_rsp_none", 32'(bus.rsp_none), 32'd0);
        apply('0, '0, 1'b0, 1'b0);

        // response, timeout, start bit on the very last listen cycle
        txn(4'b0100, 2, 8'hA5, 12, 8'h3C, 8'h3C, 1'b0, 21);
        txn(4'b0100, 2, 8'hA5, 0,  8'h00, 8'h00, 1'b1, 42);
        txn(4'b0100, 2, 8'h5A, 41, 8'hFF, 8'hFF, 1'b0, 50);

        // reset mid-SEND, then all requesters held: order from requester 0
        wd = {$urandom, $urandom};
        observe(); apply(4'b0100, wd, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            observe(); apply(4'b0100, wd, 1'b0, 1'b0);
        end
        observe(); apply(4'b0100, wd, 1'b0, 1'b1);
        observe();
        chk("abort_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_x", 32'(bus.core_x), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        apply(4'b1111, wd, 1'b0, 1'b0);
        prevg = '0;
        for (int k = 7; k <= 190; k++) begin
            observe();
            if (bus.gnt != '0 && prevg == '0) begin
                gi = 0;
                for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) gi = i;
                g_idx.push_back(gi);
                g_cyc.push_back(cur);
            end
            prevg = bus.gnt;
            apply(4'b1111, wd, 1'b0, 1'b0);
        end
        chk("fair_count", 32'(g_idx.size()), 32'd5);
        lim = (g_idx.size() < 5) ? g_idx.size() : 5;
        for (int i = 0; i < lim; i++) chk("fair_order", 32'(g_idx[i]), 32'(i % NREQ));
        for (int i = 1; i < lim; i++) chk("fair_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd44);
        observe(); apply('0, wd, 1'b0, 1'b1);

        // req drop and word change during SEND: original frame finishes
        wd = {$urandom, $urandom};
        wd[7:0] = 8'hC3; wd[15:8] = 8'h96;
        observe(); apply(4'b0011, wd, 1'b0, 1'b0);
        for (int k = 1; k <= 45; k++) begin
            observe();
            if (k <= 9) chk("drop_frame", 32'(bus.core_x), 32'(((k == 1) ? 1 : ((8'hC3 >> (9 - k)) & 1))));
            if (k == 42) chk("drop_done", 32'(bus.done), 32'd1);
            if (k == 45) chk("drop_next_gnt", 32'(bus.gnt), 32'b0010);
            if (k >= 2) wd[7:0] = 8'h3C;
            apply(4'b0010, wd, 1'b0, 1'b0);
        end
        observe(); apply('0, wd, 1'b0, 1'b1);

        // randomized traffic
        rq = '0;
        wd = {$urandom, $urandom};
        yprob = 5;
        for (int n = 0; n < 20000; n++) begin
            observe();
            for (int i = 0; i < NREQ; i++) begin
                if (rq[i]) begin
                    if (e_done && m_idx == i) rq[i] = 1'b0;
                    else if ($urandom_range(0, 199) == 0) rq[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    rq[i] = 1'b1;
                    wd[8*i +: 8] = 8'($urandom);
                end
                if ($urandom_range(0, 15) == 0) wd[8*i +: 8] = 8'($urandom);
            end
            if (n % 300 == 0) begin
                case ($urandom_range(0, 3))
                    0: yprob = 0;
                    1: yprob = 2;
                    2: yprob = 8;
                    default: yprob = 40;
                endcase
            end
            apply(rq, wd, ($urandom_range(0, 99) < yprob), ($urandom_range(0, 999) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/b09_rr_sched.md
# b09_rr_sched

Round-robin scheduler that shares one b09-class serial-to-serial converter core among `NREQ` word-level requesters. It grants the core to one requester at a time and serializes the granted 8-bit word onto the core's `X` input as a start-bit frame. It then captures the core's serial `Y` response, or flags that the core produced none (duplicate-suppressed word), and returns the result with a one-cycle `done` pulse. The block sits between the requester fabric and the converter core.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 32: max LISTEN cycles waiting for a response start bit, ≥1.
- `GUARD`, 2: idle cycles between transactions, ≥1.

- `CLOCK`  in  1  single clock, rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `word`  in  8*NREQ  requester i's word at bits [8i+7:8i].
- `gnt`  out  NREQ  one-hot grant, held SEND..done cycle.
- `done`  out  1  one-cycle transaction-complete pulse.
- `rsp_data`  out  8  captured response word.
- `rsp_none`  out  1  1 = no response within TIMEOUT.
- `busy`  out  1  state ≠ IDLE.
- `core_x`  out  1  serial frame to the converter core.
- `core_y`  in  1  serial response from the converter core.

## Operation
- States: IDLE → SEND → LISTEN → (RECV →) GUARD → IDLE.
- IDLE: if any `req` bit is high at edge T, pick the first set bit at or after `ptr`, cyclically. Load that requester's word into the shift register, set `gnt`, enter SEND.
- SEND: 9 cycles. `core_x` = 1 (start bit), then d7..d0, MSB first. Then enter LISTEN.
- LISTEN: `core_x` = 0. Sample `core_y` each cycle. A 1 → RECV. If TIMEOUT cycles pass with no 1 → GUARD with `rsp_none`=1, `rsp_data`=0x00.
- RECV: 8 cycles, shift `core_y` MSB first into `rsp_data`, then → GUARD with `rsp_none`=0.
- GUARD: lasts GUARD cycles. `done`=1 in the first GUARD cycle only. `gnt` drops after that cycle. `ptr` := granted index + 1 mod NREQ.
- `rsp_data` and `rsp_none` update only at `done` and hold until the next `done`.
- Requester holds `req` until its `done`. A `req` drop mid-transaction is ignored; the transaction completes.
- `core_y` is ignored outside LISTEN and RECV. A start bit in the final LISTEN cycle counts.
- `word` is sampled only at grant. Later changes do not affect the frame.
- Reset values: state IDLE, `gnt`=0, `done`=0, `rsp_data`=0x00, `rsp_none`=0, `busy`=0, `core_x`=0, `ptr`=0.
- `RESET` in any state returns to IDLE next edge. No `done` is issued for the aborted transaction.

## Timing
- Request seen at edge T → `gnt` and `core_x` start bit at cycle T+1. Data bits on T+2..T+9. LISTEN entered at T+10.
- Start bit sampled at LISTEN cycle L → data bits sampled at L+1..L+8 → `done` at L+9. Minimum: `done` at T+19.
- No response → `done` at T+10+TIMEOUT, which is T+42 by default.
- `done` at D → IDLE at D+GUARD → earliest next `gnt` at D+GUARD+1.
- `busy` is registered and high from T+1 through D+GUARD-1.
- All outputs are registered. No combinational path from `req` or `core_y` to any output.

## Test plan
- Single request: `req`=0100, word2=0xA5 at T → `gnt`=0100 at T+1. `core_x` = 1,1,0,1,0,0,1,0,1 on T+1..T+9, then 0. `core_y` = 1 at T+12, then 0x3C MSB first → `done` at T+21 with `rsp_data`=0x3C, `rsp_none`=0.
- Timeout: same request, `core_y` held 0 → `done` at exactly T+42, `rsp_none`=1, `rsp_data`=0x00. `busy` low from T+44.
- Fairness: all `req`=1111 held → grant order 0,1,2,3,0. Successive grants are spaced by transaction length + GUARD + 1.
- Late start: `core_y` first 1 at LISTEN cycle 32 (T+41), then 0xFF → RECV taken, `done` at T+50 with `rsp_data`=0xFF.
- Reset mid-SEND: RESET at T+5 → at T+6 `gnt`=0, `core_x`=0, `busy`=0, no `done`. Next request granted to requester 0 first (`ptr`=0).
- Mid-transaction drop and `word` change: `req` deasserted and `word` changed during SEND → original frame completes and `done` fires normally. The next grant goes to the next pending requester.
